// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing generator and cell-colour scanout.
// Counts pixels and lines, tracks which 16x12 cell the beam is in without
// dividers, and registers RGB/sync one pixel behind the counters.
// Optional build macro GRID_LINES_EN: paints the first row/column of every
// visible cell grey (4'h3 on each channel) instead of the cell colour.
module vga_scanout #(
    parameter int CLK_DIV = 4,
    parameter int BSIZE   = 40,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] cellColors [0:191],
    output logic [9:0]  horizCount,
    output logic [9:0]  vertCount,
    output logic        pixelTick,
    output logic        activeVideo,
    output logic        frameStart,
    output logic [3:0]  vgaRed,
    output logic [3:0]  vgaGreen,
    output logic [3:0]  vgaBlue,
    output logic        hsync,
    output logic        vsync
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PIX_W = (BSIZE > 1) ? $clog2(BSIZE) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(BSIZE - 1);
    localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);

    localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
    localparam logic [9:0] H_VIS_C    = 10'(H_VIS);
    localparam logic [9:0] H_VIS_LAST = 10'(H_VIS - 1);
    localparam logic [9:0] HS_BEG     = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0] V_VIS_C    = 10'(V_VIS);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VIS - 1);
    localparam logic [9:0] VS_BEG     = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q,  div_d;
    logic [9:0]       h_q,    h_d;
    logic [9:0]       v_q,    v_d;
    logic [PIX_W-1:0] pxx_q,  pxx_d;
    logic [PIX_W-1:0] pxy_q,  pxy_d;
    logic [3:0]       cx_q,   cx_d;
    logic [3:0]       cy_q,   cy_d;
    logic [11:0]      color_q, color_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             av_q,    av_d;

    logic             tick, h_wrap, v_wrap, visible;
    logic [7:0]       cell_idx;

    assign tick   = (div_q == DIV_LAST);
    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);

    // Next-state for divider, beam counters and cell counters.
    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
        h_d   = h_q;
        v_d   = v_q;
        pxx_d = pxx_q;
        cx_d  = cx_q;
        pxy_d = pxy_q;
        cy_d  = cy_q;
        if (tick) begin
            if (h_wrap) begin
                h_d   = '0;
                pxx_d = '0;
                cx_d  = '0;
                if (v_wrap) begin
                    v_d   = '0;
                    pxy_d = '0;
                    cy_d  = '0;
                end else begin
                    v_d = v_q + 10'd1;
                    // Cell row only advances inside the visible lines; it
                    // freezes on the last visible line so it cannot overrun.
                    if (v_q < V_VIS_LAST) begin
                        if (pxy_q == PIX_LAST) begin
                            pxy_d = '0;
                            cy_d  = cy_q + 4'd1;
                        end else begin
                            pxy_d = pxy_q + PIX_ONE;
                        end
                    end
                end
            end else begin
                h_d = h_q + 10'd1;
                if (h_q < H_VIS_LAST) begin
                    if (pxx_q == PIX_LAST) begin
                        pxx_d = '0;
                        cx_d  = cx_q + 4'd1;
                    end else begin
                        pxx_d = pxx_q + PIX_ONE;
                    end
                end
            end
        end
    end

    // Output values for the current (pre-tick) beam position.
    always_comb begin
        visible  = (h_q < H_VIS_C) && (v_q < V_VIS_C);
        cell_idx = {cy_q, 4'b0000} + {4'b0000, cx_q};
        // Never let a stale blanking-time counter reach the colour array.
        if (!visible || (cy_q > 4'd11)) begin
            cell_idx = 8'd0;
        end
        color_d = visible ? cellColors[cell_idx] : 12'h000;
`ifdef GRID_LINES_EN
        if (visible && ((pxx_q == '0) || (pxy_q == '0))) begin
            color_d = 12'h333;
        end
`endif
        hsync_d = !((h_q >= HS_BEG) && (h_q < HS_END));
        vsync_d = !((v_q >= VS_BEG) && (v_q < VS_END));
        av_d    = visible;
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            pxx_q <= '0;
            cx_q  <= '0;
            pxy_q <= '0;
            cy_q  <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            pxx_q <= pxx_d;
            cx_q  <= cx_d;
            pxy_q <= pxy_d;
            cy_q  <= cy_d;
        end
    end

    // Output registers: capture the pre-tick pixel, hold between ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            color_q <= 12'h000;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            av_q    <= 1'b0;
        end else if (tick) begin
            color_q <= color_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            av_q    <= av_d;
        end
    end

    assign horizCount  = h_q;
    assign vertCount   = v_q;
    assign pixelTick   = tick;
    assign frameStart  = tick && h_wrap && v_wrap;
    assign activeVideo = av_q;
    assign vgaRed      = color_q[11:8];
    assign vgaGreen    = color_q[7:4];
    assign vgaBlue     = color_q[3:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: one full-timing instance (CLK_DIV=4) for reset
// release and a complete first line, plus a scaled-down instance
// (4-px cells, 72x54 total) for frame-level, pixel-map and reset corners.
module tb_vga_scanout;

    localparam int SD  = 2;
    localparam int SB  = 4;
    localparam int SHV = 64;
    localparam int SVV = 48;
    localparam int SHT = 72;
    localparam int SVT = 54;
    localparam int SFT = SHT * SVT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_f, rst_s;
    logic [11:0] colors_f [0:191];
    logic [11:0] colors_s [0:191];

    logic [9:0] hc_f, vc_f, hc_s, vc_s;
    logic       tick_f, av_f, fs_f, hs_f, vs_f;
    logic       tick_s, av_s, fs_s, hs_s, vs_s;
    logic [3:0] r_f, g_f, b_f, r_s, g_s, b_s;
    logic [11:0] rgb_f, rgb_s;
    assign rgb_f = {r_f, g_f, b_f};
    assign rgb_s = {r_s, g_s, b_s};

    vga_scanout u_full (
        .clk(clk), .reset(rst_f), .cellColors(colors_f),
        .horizCount(hc_f), .vertCount(vc_f), .pixelTick(tick_f),
        .activeVideo(av_f), .frameStart(fs_f),
        .vgaRed(r_f), .vgaGreen(g_f), .vgaBlue(b_f),
        .hsync(hs_f), .vsync(vs_f)
    );

    vga_scanout #(
        .CLK_DIV(SD), .BSIZE(SB),
        .H_VIS(SHV), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VIS(SVV), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .clk(clk), .reset(rst_s), .cellColors(colors_s),
        .horizCount(hc_s), .vertCount(vc_s), .pixelTick(tick_s),
        .activeVideo(av_s), .frameStart(fs_s),
        .vgaRed(r_s), .vgaGreen(g_s), .vgaBlue(b_s),
        .hsync(hs_s), .vsync(vs_s)
    );

    // Clock counts since the last clock edge that sampled reset high.
    int cyc_f, cyc_s;
    always @(posedge clk) cyc_f <= rst_f ? 0 : cyc_f + 1;
    always @(posedge clk) cyc_s <= rst_s ? 0 : cyc_s + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_f(input int target);
        int guard = 0;
        while (cyc_f != target && guard < 50000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc_f != target) chk("wait_full_timeout", cyc_f, target);
    endtask

    task automatic wait_s(input int target);
        int guard = 0;
        while (cyc_s != target && guard < 50000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc_s != target) chk("wait_small_timeout", cyc_s, target);
    endtask

    function automatic logic [11:0] grid_adj(input int h, input int v, input int bs,
                                            input int hv, input int vv, input logic [11:0] c);
`ifdef GRID_LINES_EN
        if (h < hv && v < vv && ((h % bs) == 0 || (v % bs) == 0)) return 12'h333;
`endif
        return c;
    endfunction

    function automatic logic [11:0] exp_small(input int h, input int v);
        if (h >= SHV || v >= SVV) return 12'h000;
        return grid_adj(h, v, SB, SHV, SVV, colors_s[(h / SB) + (v / SB) * 16]);
    endfunction

    // Scan one small-instance frame whose first tick edge is base+SD.
    task automatic scan_frame(input string tag, input int base);
        int av_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0, fs_at = -1;
        int blank_bad = 0, pix_bad = 0;
        for (int c = 1; c <= SD * SFT; c++) begin
            @(negedge clk);
            if (fs_s) begin
                fs_cnt++;
                fs_at = cyc_s;
            end
            if ((cyc_s % SD) == 0) begin
                int n, h, v;
                n = (cyc_s / SD - 1) % SFT;
                h = n % SHT;
                v = n / SHT;
                if (av_s) av_cnt++;
                if (!hs_s) hs_cnt++;
                if (!vs_s) vs_cnt++;
                if (!av_s && rgb_s != 12'h000) blank_bad++;
                if (rgb_s != exp_small(h, v)) pix_bad++;
            end
        end
        chk({tag, "_active_ticks"}, av_cnt, SHV * SVV);
        chk({tag, "_hsync_low_ticks"}, hs_cnt, 4 * SVT);
        chk({tag, "_vsync_low_ticks"}, vs_cnt, 2 * SHT);
        chk({tag, "_framestart_count"}, fs_cnt, 1);
        chk({tag, "_framestart_cycle"}, fs_at, base + SD * SFT - 1);
        chk({tag, "_rgb_in_blanking"}, blank_bad, 0);
        chk({tag, "_pixel_colour_errs"}, pix_bad, 0);
    endtask

    typedef struct {
        int          f;
        int          h;
        int          v;
        logic [11:0] rgb;
        logic        av;
        logic        hs;
        logic        vs;
        int          hc;
        int          vc;
    } probe_t;

    probe_t tbl[$];

    initial begin
        int first_tick, hs_cnt, hs_first, av_cnt, idle_bad;
        logic [11:0] px0, px39, px40;

        // Small-instance probe table: pixel shown after its tick, plus the
        // counters which by then point at the following pixel.
        tbl.push_back('{0,  0,  0, 12'hF00, 1'b1, 1'b1, 1'b1,  1,  0});
        tbl.push_back('{0,  3,  0, 12'hF00, 1'b1, 1'b1, 1'b1,  4,  0});
        tbl.push_back('{0,  4,  0, 12'h000, 1'b1, 1'b1, 1'b1,  5,  0});
        tbl.push_back('{0,  4,  4, 12'h0F0, 1'b1, 1'b1, 1'b1,  5,  4});
        tbl.push_back('{0,  7,  7, 12'h0F0, 1'b1, 1'b1, 1'b1,  8,  7});
        tbl.push_back('{0,  8,  7, 12'h000, 1'b1, 1'b1, 1'b1,  9,  7});
        tbl.push_back('{0, 63,  7, 12'h000, 1'b1, 1'b1, 1'b1, 64,  7});
        tbl.push_back('{0, 64,  7, 12'h000, 1'b0, 1'b1, 1'b1, 65,  7});
        tbl.push_back('{0, 65,  7, 12'h000, 1'b0, 1'b1, 1'b1, 66,  7});
        tbl.push_back('{0, 66,  7, 12'h000, 1'b0, 1'b0, 1'b1, 67,  7});
        tbl.push_back('{0, 69,  7, 12'h000, 1'b0, 1'b0, 1'b1, 70,  7});
        tbl.push_back('{0, 70,  7, 12'h000, 1'b0, 1'b1, 1'b1, 71,  7});
        tbl.push_back('{0, 71,  7, 12'h000, 1'b0, 1'b1, 1'b1,  0,  8});
        tbl.push_back('{0, 59, 44, 12'h000, 1'b1, 1'b1, 1'b1, 60, 44});
        tbl.push_back('{0, 60, 44, 12'h00F, 1'b1, 1'b1, 1'b1, 61, 44});
        tbl.push_back('{0, 63, 47, 12'h00F, 1'b1, 1'b1, 1'b1, 64, 47});
        tbl.push_back('{0,  0, 48, 12'h000, 1'b0, 1'b1, 1'b1,  1, 48});
        tbl.push_back('{0,  5, 49, 12'h000, 1'b0, 1'b1, 1'b1,  6, 49});
        tbl.push_back('{0,  5, 50, 12'h000, 1'b0, 1'b1, 1'b0,  6, 50});
        tbl.push_back('{0, 71, 51, 12'h000, 1'b0, 1'b1, 1'b0,  0, 52});
        tbl.push_back('{0,  0, 52, 12'h000, 1'b0, 1'b1, 1'b1,  1, 52});
        tbl.push_back('{1,  0,  0, 12'hF00, 1'b1, 1'b1, 1'b1,  1,  0});

        for (int i = 0; i < 192; i++) begin
            colors_f[i] = 12'h000;
            colors_s[i] = 12'h000;
        end
        colors_f[0] = 12'hF00; colors_f[17] = 12'h0F0; colors_f[191] = 12'h00F;
        colors_s[0] = 12'hF00; colors_s[17] = 12'h0F0; colors_s[191] = 12'h00F;

        rst_f = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(negedge clk);

        // Full-timing instance: reset values and first tick.
        rst_f = 1'b0;
        chk("full_reset_hcount", hc_f, 0);
        chk("full_reset_vcount", vc_f, 0);
        chk("full_reset_tick", tick_f, 0);
        chk("full_reset_active", av_f, 0);
        chk("full_reset_framestart", fs_f, 0);
        chk("full_reset_rgb", rgb_f, 0);
        chk("full_reset_hsync", hs_f, 1);
        chk("full_reset_vsync", vs_f, 1);
        first_tick = tick_f ? 0 : -1;
        idle_bad = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (tick_f && first_tick < 0) first_tick = cyc_f;
            if (!hs_f || !vs_f || rgb_f != 12'h000 || av_f) idle_bad++;
        end
        chk("full_first_tick_cycle", first_tick, 3);
        chk("full_idle_before_first_tick", idle_bad, 0);

        // Full-timing instance: whole first line.
        hs_cnt = 0; hs_first = -1; av_cnt = 0;
        px0 = 12'hAAA; px39 = 12'hAAA; px40 = 12'hAAA;
        for (int n = 0; n < 800; n++) begin
            wait_f(4 * (n + 1));
            if (!hs_f) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = n;
            end
            if (av_f) av_cnt++;
            if (n == 0)  px0  = rgb_f;
            if (n == 39) px39 = rgb_f;
            if (n == 40) px40 = rgb_f;
        end
        chk("full_hsync_low_ticks", hs_cnt, 96);
        chk("full_hsync_first_low_h", hs_first, 656);
        chk("full_active_ticks_line0", av_cnt, 640);
        chk("full_rgb_0_0", px0, grid_adj(0, 0, 40, 640, 480, 12'hF00));
        chk("full_rgb_39_0", px39, grid_adj(39, 0, 40, 640, 480, 12'hF00));
        chk("full_rgb_40_0", px40, grid_adj(40, 0, 40, 640, 480, 12'h000));
        chk("full_line1_hcount", hc_f, 0);
        chk("full_line1_vcount", vc_f, 1);

        // Small instance: table-driven pixel probes.
        rst_s = 1'b0;
        foreach (tbl[i]) begin
            int n;
            n = tbl[i].f * SFT + tbl[i].v * SHT + tbl[i].h;
            wait_s(SD * (n + 1));
            chk($sformatf("rgb(%0d,%0d,f%0d)", tbl[i].h, tbl[i].v, tbl[i].f), rgb_s,
                grid_adj(tbl[i].h, tbl[i].v, SB, SHV, SVV, tbl[i].rgb));
            chk($sformatf("active(%0d,%0d)", tbl[i].h, tbl[i].v), av_s, tbl[i].av);
            chk($sformatf("hsync(%0d,%0d)", tbl[i].h, tbl[i].v), hs_s, tbl[i].hs);
            chk($sformatf("vsync(%0d,%0d)", tbl[i].h, tbl[i].v), vs_s, tbl[i].vs);
            chk($sformatf("hcount_after(%0d,%0d)", tbl[i].h, tbl[i].v), hc_s, tbl[i].hc);
            chk($sformatf("vcount_after(%0d,%0d)", tbl[i].h, tbl[i].v), vc_s, tbl[i].vc);
        end

        // Small instance: fresh start, pattern frame then all-white frame.
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        scan_frame("pattern", 0);
        for (int i = 0; i < 192; i++) colors_s[i] = 12'hFFF;
        scan_frame("white", SD * SFT);

        // Mid-frame reset with the beam at (30,20) of the third frame.
        wait_s(SD * (2 * SFT + 20 * SHT + 30));
        chk("pre_reset_hcount", hc_s, 30);
        chk("pre_reset_vcount", vc_s, 20);
        chk("pre_reset_rgb", rgb_s, grid_adj(29, 20, SB, SHV, SVV, 12'hFFF));
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        chk("mid_reset_hcount", hc_s, 0);
        chk("mid_reset_vcount", vc_s, 0);
        chk("mid_reset_tick", tick_s, 0);
        chk("mid_reset_active", av_s, 0);
        chk("mid_reset_framestart", fs_s, 0);
        chk("mid_reset_rgb", rgb_s, 0);
        chk("mid_reset_hsync", hs_s, 1);
        chk("mid_reset_vsync", vs_s, 1);
        scan_frame("after_reset", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
